// File: rtl/uart_parity_checker.sv
// UART frame parity checker: one output register, one cycle from accept to out_valid.
// Backpressure: in_ready = !out_valid || out_ready, so a stalled output holds and blocks input.
module uart_parity_checker #(
  parameter int DATA_W      = 8,
  parameter int CNT_W       = 16,
  parameter bit DROP_ON_ERR = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        par_mode,
  input  logic [DATA_W:0]   in_frame,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  err_cnt,
  input  logic              err_clr
);

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10,
    PAR_MARK = 2'b11
  } par_mode_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_err_q, out_err_d;
  logic              out_valid_q, out_valid_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic [DATA_W-1:0] frame_data;
  logic              frame_par;
  logic              frame_bad;
  logic              in_xfer;
  logic              out_xfer;
  logic              bad_xfer;

  assign frame_data = in_frame[DATA_W-1:0];
  assign frame_par  = in_frame[DATA_W];

  always_comb begin
    frame_bad = 1'b0;
    case (par_mode_e'(par_mode))
      PAR_EVEN: frame_bad = ((^frame_data) != frame_par);
      PAR_ODD:  frame_bad = ((~^frame_data) != frame_par);
      PAR_MARK: frame_bad = !frame_par;
      default:  frame_bad = 1'b0;
    endcase
  end

  assign in_ready = !out_valid_q || out_ready;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid_q && out_ready;
  assign bad_xfer = in_xfer && frame_bad;

  // A dropped bad frame leaves the register untouched, so out_valid only falls if the
  // current word is leaving this cycle.
  always_comb begin
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    out_valid_d = out_valid_q;
    if (out_xfer) begin
      out_valid_d = 1'b0;
    end
    if (in_xfer) begin
      if (!frame_bad) begin
        out_data_d  = frame_data;
        out_err_d   = 1'b0;
        out_valid_d = 1'b1;
      end else if (!DROP_ON_ERR) begin
        out_data_d  = '0;
        out_err_d   = 1'b1;
        out_valid_d = 1'b1;
      end
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = bad_xfer ? CNT_ONE : '0;
    end else if (bad_xfer && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
  assign out_valid = out_valid_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_uart_parity_checker.sv
// Bench for uart_parity_checker: forwarding instance (defaults) and a dropping, 2-bit-counter instance.
module tb_uart_parity_checker;

  logic        clk;
  logic        rst_n;
  logic [1:0]  par_mode;
  logic [8:0]  in_frame;
  logic        in_valid;
  logic        out_ready;
  logic        err_clr;

  logic        in_ready_a, out_err_a, out_valid_a;
  logic [7:0]  out_data_a;
  logic [15:0] err_cnt_a;
  logic        in_ready_b, out_err_b, out_valid_b;
  logic [7:0]  out_data_b;
  logic [1:0]  err_cnt_b;

  int errors = 0;
  int checks = 0;

  uart_parity_checker #(.DATA_W(8), .CNT_W(16), .DROP_ON_ERR(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .par_mode(par_mode), .in_frame(in_frame),
    .in_valid(in_valid), .in_ready(in_ready_a), .out_data(out_data_a),
    .out_err(out_err_a), .out_valid(out_valid_a), .out_ready(out_ready),
    .err_cnt(err_cnt_a), .err_clr(err_clr)
  );

  uart_parity_checker #(.DATA_W(8), .CNT_W(2), .DROP_ON_ERR(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .par_mode(par_mode), .in_frame(in_frame),
    .in_valid(in_valid), .in_ready(in_ready_b), .out_data(out_data_b),
    .out_err(out_err_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .err_cnt(err_cnt_b), .err_clr(err_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Output transfers as seen at each rising edge, with the cycle they happened in.
  logic [7:0] q_a[$];
  int         t_a[$];
  logic [7:0] q_b[$];
  int         cyc = 0;
  always @(posedge clk) begin
    if (rst_n && out_valid_a && out_ready) begin
      q_a.push_back(out_data_a);
      t_a.push_back(cyc);
    end
    if (rst_n && out_valid_b && out_ready) q_b.push_back(out_data_b);
    cyc = cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    err_clr  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [1:0] mode;
    logic [8:0] frame;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;

  vec_t vecs[10];
  logic [15:0] exp_cnt;
  logic [8:0]  bp_frames[3];
  int          bp_ptr;

  initial begin
    vecs[0] = '{2'b01, 9'h0_A5, 8'hA5, 1'b0};
    vecs[1] = '{2'b01, 9'h1_A5, 8'h00, 1'b1};
    vecs[2] = '{2'b10, 9'h1_A5, 8'hA5, 1'b0};
    vecs[3] = '{2'b10, 9'h0_A5, 8'h00, 1'b1};
    vecs[4] = '{2'b00, 9'h1_3C, 8'h3C, 1'b0};
    vecs[5] = '{2'b11, 9'h0_FF, 8'h00, 1'b1};
    vecs[6] = '{2'b11, 9'h1_00, 8'h00, 1'b0};
    vecs[7] = '{2'b01, 9'h1_01, 8'h01, 1'b0};
    vecs[8] = '{2'b10, 9'h0_07, 8'h07, 1'b0};
    vecs[9] = '{2'b01, 9'h0_80, 8'h00, 1'b1};

    // Reset state, with a bad frame offered while reset is held.
    rst_n     = 1'b0;
    par_mode  = 2'b01;
    in_frame  = 9'h1_A5;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_out_valid", out_valid_a, 1'b0);
    check("rst_out_data", out_data_a, 8'h00);
    check("rst_out_err", out_err_a, 1'b0);
    check("rst_err_cnt", err_cnt_a, 16'd0);
    check("rst_in_ready", in_ready_a, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_idle_valid", out_valid_a, 1'b0);

    // Table of single frames at full throughput.
    out_ready = 1'b1;
    exp_cnt   = 16'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      par_mode = vecs[i].mode;
      in_frame = vecs[i].frame;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      if (vecs[i].exp_err) exp_cnt = exp_cnt + 16'd1;
      check($sformatf("vec%0d_valid", i), out_valid_a, 1'b1);
      check($sformatf("vec%0d_data", i), out_data_a, vecs[i].exp_data);
      check($sformatf("vec%0d_err", i), out_err_a, vecs[i].exp_err);
      check($sformatf("vec%0d_cnt", i), err_cnt_a, exp_cnt);
    end

    // Output drains with nothing behind it; data/err hold.
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("drain_valid", out_valid_a, 1'b0);
    check("drain_data_hold", out_data_a, 8'h00);
    check("drain_err_hold", out_err_a, 1'b1);

    // Clear alone, then clear together with a bad frame.
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    check("clr_alone_cnt", err_cnt_a, 16'd0);
    @(negedge clk);
    par_mode = 2'b01;
    in_frame = 9'h1_A5;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("clr_bad_cnt", err_cnt_a, 16'd1);
    check("clr_bad_err", out_err_a, 1'b1);
    @(negedge clk);
    err_clr  = 1'b0;
    in_valid = 1'b0;

    // Dropping instance: good / bad / good.
    do_reset();
    out_ready = 1'b1;
    par_mode  = 2'b01;
    q_b.delete();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_frame = (i == 0) ? 9'h0_03 : (i == 1) ? 9'h0_01 : 9'h0_0F;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("drop_count", q_b.size(), 2);
    if (q_b.size() == 2) begin
      check("drop_first", q_b[0], 8'h03);
      check("drop_second", q_b[1], 8'h0F);
    end
    check("drop_err_cnt", err_cnt_b, 2'd1);

    // Counter saturation on the 2-bit instance.
    do_reset();
    par_mode = 2'b11;
    in_frame = 9'h0_55;
    in_valid = 1'b1;
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("sat_cnt", err_cnt_b, 2'd3);
    check("sat_no_output", out_valid_b, 1'b0);
    @(negedge clk);
    err_clr  = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    err_clr  = 1'b0;
    in_valid = 1'b0;
    #1;
    check("sat_clr_bad_cnt", err_cnt_b, 2'd1);

    // Back-pressure: three frames, output stalled for five cycles.
    do_reset();
    bp_frames[0] = 9'h0_11;
    bp_frames[1] = 9'h0_22;
    bp_frames[2] = 9'h0_33;
    q_a.delete();
    t_a.delete();
    par_mode  = 2'b00;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_frame  = bp_frames[0];
    #1;
    check("bp_first_ready", in_ready_a, 1'b1);
    bp_ptr = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_frame = bp_frames[bp_ptr];
      #1;
      check($sformatf("bp_hold%0d_ready", i), in_ready_a, 1'b0);
      check($sformatf("bp_hold%0d_valid", i), out_valid_a, 1'b1);
      check($sformatf("bp_hold%0d_data", i), out_data_a, 8'h11);
    end
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && bp_ptr < 3; i++) begin
      in_frame = bp_frames[bp_ptr];
      #1;
      if (in_ready_a) bp_ptr++;
      @(negedge clk);
    end
    check("bp_all_accepted", bp_ptr, 3);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("bp_out_count", q_a.size(), 3);
    if (q_a.size() == 3) begin
      check("bp_out0", q_a[0], 8'h11);
      check("bp_out1", q_a[1], 8'h22);
      check("bp_out2", q_a[2], 8'h33);
      check("bp_rate01", t_a[1] - t_a[0], 1);
      check("bp_rate12", t_a[2] - t_a[1], 1);
    end

    // Asynchronous reset while a stalled bad frame is held.
    do_reset();
    out_ready = 1'b0;
    par_mode  = 2'b01;
    in_frame  = 9'h1_A5;
    in_valid  = 1'b1;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    check("arst_pre_valid", out_valid_a, 1'b1);
    check("arst_pre_cnt", err_cnt_a, 16'd1);
    rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid_a, 1'b0);
    check("arst_cnt", err_cnt_a, 16'd0);
    check("arst_cnt_b", err_cnt_b, 2'd0);
    check("arst_err", out_err_a, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
